hyperram_req_sequencer: RTL and testbench

- Upstream request sequencer between the system Avalon-MM host and the HyperRAM controller s0 port.
- Queues host reads and writes in a command FIFO and replays them one at a time as isolated strobes, with a guaranteed low gap between them. The controller acts only on strobe rising edges.
- Returns read data in order and holds the host off with waitrequest when the queue is full.
- Times out lost reads and returns a fixed error word.

---
 rtl/hyperram_req_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_hyperram_req_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hyperram_req_sequencer
// Brief    : Queues Avalon-MM host reads/writes in a command FIFO and replays
//            them to the HyperRAM controller s0 port as isolated strobes with
//            a guaranteed low gap, returning read data in order and timing
//            out reads that never complete.
// Revision : 1.0 - initial release
// ============================================================================
module hyperram_req_sequencer #(
    parameter int DEPTH       = 8,
    parameter int STROBE_CYC  = 2,
    parameter int WR_WAIT_CYC = 48,
    parameter int GAP_CYC     = 2,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] h_address,
    input  logic        h_read,
    input  logic        h_write,
    input  logic [31:0] h_writedata,
    output logic        h_waitrequest,
    output logic [31:0] h_readdata,
    output logic        h_readdatavalid,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    output logic        busy,
    output logic        rd_timeout_err,
    output logic        proto_err
);

    localparam int c_AW       = $clog2(DEPTH);
    localparam int c_MAX_A    = (RD_TIMEOUT > WR_WAIT_CYC) ? RD_TIMEOUT : WR_WAIT_CYC;
    localparam int c_MAX_B    = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
    localparam int c_CNT_MAX  = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);
    localparam logic [c_AW:0]      c_PTR_ONE   = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_STB   = c_CNT_W'(STROBE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_RD    = c_CNT_W'(RD_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_WR    = c_CNT_W'(WR_WAIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_GAP   = c_CNT_W'(GAP_CYC - 1);
    localparam logic [31:0]        c_ERR_WORD  = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STROBE  = 3'd1,
        S_WAIT_RD = 3'd2,
        S_WAIT_WR = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    // FIFO storage and pointers; entry = {is_write, address, writedata}
    logic [64:0]    r_mem [DEPTH];
    logic [c_AW:0]  r_wr_ptr;
    logic [c_AW:0]  r_rd_ptr;
    logic [c_AW:0]  r_wr_ptr_vis;
    logic           w_empty;
    logic           w_empty_vis;
    logic           w_full;
    logic           w_accept;
    logic           w_pop;
    logic [64:0]    w_head;

    // FSM state, counter and registered outputs with their next values
    state_t             r_state, w_state_next;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_next;
    logic               r_is_write, w_is_write_next;
    logic               r_m_read, w_m_read_next;
    logic               r_m_write, w_m_write_next;
    logic [31:0]        r_m_address, w_m_address_next;
    logic [31:0]        r_m_writedata, w_m_writedata_next;
    logic [31:0]        r_h_readdata, w_h_readdata_next;
    logic               r_h_readdatavalid, w_h_readdatavalid_next;
    logic               r_rd_timeout_err, w_rd_timeout_err_next;
    logic               r_proto_err;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    // The pop side sees writes one cycle late, giving the storage a full cycle
    // before the head is read out.
    assign w_empty_vis = (r_wr_ptr_vis == r_rd_ptr);
    assign w_accept = (h_read | h_write) & ~w_full;
    assign w_head   = r_mem[r_rd_ptr[c_AW-1:0]];

    // Capture accepted host requests; a write wins when both strobes are set
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {h_write, h_address, h_writedata};
        end
    end

    // FIFO pointer maintenance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr_vis <= '0;
        end else begin
            r_wr_ptr_vis <= r_wr_ptr;
            if (w_accept) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Sticky flag for simultaneous read and write on an accepted cycle
    always_ff @(posedge clk) begin
        if (rst) r_proto_err <= 1'b0;
        else     r_proto_err <= r_proto_err | (w_accept & h_read & h_write);
    end

    // FSM state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_cnt             <= '0;
            r_is_write        <= 1'b0;
            r_m_read          <= 1'b0;
            r_m_write         <= 1'b0;
            r_m_address       <= '0;
            r_m_writedata     <= '0;
            r_h_readdata      <= '0;
            r_h_readdatavalid <= 1'b0;
            r_rd_timeout_err  <= 1'b0;
        end else begin
            r_state           <= w_state_next;
            r_cnt             <= w_cnt_next;
            r_is_write        <= w_is_write_next;
            r_m_read          <= w_m_read_next;
            r_m_write         <= w_m_write_next;
            r_m_address       <= w_m_address_next;
            r_m_writedata     <= w_m_writedata_next;
            r_h_readdata      <= w_h_readdata_next;
            r_h_readdatavalid <= w_h_readdatavalid_next;
            r_rd_timeout_err  <= w_rd_timeout_err_next;
        end
    end

    // Next-state and output decode for the command replay sequence
    always_comb begin
        w_state_next           = r_state;
        w_cnt_next             = r_cnt;
        w_pop                  = 1'b0;
        w_is_write_next        = r_is_write;
        w_m_read_next          = r_m_read;
        w_m_write_next         = r_m_write;
        w_m_address_next       = r_m_address;
        w_m_writedata_next     = r_m_writedata;
        w_h_readdata_next      = r_h_readdata;
        w_h_readdatavalid_next = 1'b0;
        w_rd_timeout_err_next  = r_rd_timeout_err;
        case (r_state)
            S_IDLE: begin
                if (!w_empty_vis) begin
                    w_pop              = 1'b1;
                    w_is_write_next    = w_head[64];
                    w_m_address_next   = w_head[63:32];
                    w_m_writedata_next = w_head[31:0];
                    w_m_read_next      = ~w_head[64];
                    w_m_write_next     = w_head[64];
                    w_cnt_next         = c_CNT_STB;
                    w_state_next       = S_STROBE;
                end
            end
            S_STROBE: begin
                if (r_cnt == '0) begin
                    w_m_read_next  = 1'b0;
                    w_m_write_next = 1'b0;
                    if (r_is_write) begin
                        w_cnt_next   = c_CNT_WR;
                        w_state_next = S_WAIT_WR;
                    end else begin
                        w_cnt_next   = c_CNT_RD;
                        w_state_next = S_WAIT_RD;
                    end
                end else begin
                    w_cnt_next = r_cnt - c_CNT_ONE;
                end
            end
            S_WAIT_RD: begin
                // Real data takes priority over a timeout in the same cycle
                if (m_readdatavalid) begin
                    w_h_readdata_next      = m_readdata;
                    w_h_readdatavalid_next = 1'b1;
                    w_cnt_next             = c_CNT_GAP;
                    w_state_next           = S_GAP;
                end else if (r_cnt == '0) begin
                    w_h_readdata_next      = c_ERR_WORD;
                    w_h_readdatavalid_next = 1'b1;
                    w_rd_timeout_err_next  = 1'b1;
                    w_cnt_next             = c_CNT_GAP;
                    w_state_next           = S_GAP;
                end else begin
                    w_cnt_next = r_cnt - c_CNT_ONE;
                end
            end
            S_WAIT_WR: begin
                if (r_cnt == '0) begin
                    w_cnt_next   = c_CNT_GAP;
                    w_state_next = S_GAP;
                end else begin
                    w_cnt_next = r_cnt - c_CNT_ONE;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) w_state_next = S_IDLE;
                else             w_cnt_next   = r_cnt - c_CNT_ONE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign h_waitrequest   = w_full;
    assign h_readdata      = r_h_readdata;
    assign h_readdatavalid = r_h_readdatavalid;
    assign m_address       = r_m_address;
    assign m_read          = r_m_read;
    assign m_write         = r_m_write;
    assign m_writedata     = r_m_writedata;
    assign busy            = ~w_empty | (r_state != S_IDLE);
    assign rd_timeout_err  = r_rd_timeout_err;
    assign proto_err       = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_hyperram_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hyperram_req_sequencer
// Brief    : Scoreboard bench for hyperram_req_sequencer with a simple
//            controller model answering reads from a small memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hyperram_req_sequencer;

    localparam int c_WR_PERIOD = 2 + 48 + 2 + 1;

    logic        clk;
    logic        rst;
    logic [31:0] h_address;
    logic        h_read;
    logic        h_write;
    logic [31:0] h_writedata;
    logic        h_waitrequest;
    logic [31:0] h_readdata;
    logic        h_readdatavalid;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic        busy;
    logic        rd_timeout_err;
    logic        proto_err;

    hyperram_req_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .h_address       (h_address),
        .h_read          (h_read),
        .h_write         (h_write),
        .h_writedata     (h_writedata),
        .h_waitrequest   (h_waitrequest),
        .h_readdata      (h_readdata),
        .h_readdatavalid (h_readdatavalid),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .busy            (busy),
        .rd_timeout_err  (rd_timeout_err),
        .proto_err       (proto_err)
    );

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } cmd_t;

    typedef struct {
        logic [31:0] d;
        int          lat;
    } rsp_t;

    cmd_t        exp_cmd[$];
    rsp_t        exp_rsp[$];
    logic [31:0] ctl_mem[logic [31:0]];
    logic        ctl_respond;
    logic        chk_spacing;
    int          n_total;
    int          n_pass;
    int          n_rises;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Controller model: records writes, answers reads 10 cycles after strobe fall
    initial begin
        logic pr;
        logic pw;
        int   cd;
        pr = 1'b0;
        pw = 1'b0;
        cd = 0;
        m_readdata      = '0;
        m_readdatavalid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_readdatavalid = 1'b0;
            if (rst) begin
                cd = 0;
                pr = 1'b0;
                pw = 1'b0;
            end else begin
                if (m_write && !pw) ctl_mem[m_address] = m_writedata;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        m_readdatavalid = 1'b1;
                        m_readdata = ctl_mem.exists(m_address) ? ctl_mem[m_address] : 32'h0;
                    end
                end
                if (!m_read && pr && ctl_respond) cd = 10;
                pr = m_read;
                pw = m_write;
            end
        end
    end

    // Monitor: checks strobes and responses against the scoreboard queues
    initial begin
        logic pr;
        logic pw;
        logic rise_r;
        logic rise_w;
        int   cyc;
        int   hi_run;
        int   lo_run;
        int   last_rd_fall;
        int   prev_rise;
        logic have_prev;
        cmd_t c;
        rsp_t r;
        pr = 1'b0; pw = 1'b0; cyc = 0; hi_run = 0; lo_run = 100;
        last_rd_fall = 0; prev_rise = 0; have_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                pr = 1'b0; pw = 1'b0; hi_run = 0; lo_run = 100; have_prev = 1'b0;
                continue;
            end
            rise_r = m_read && !pr;
            rise_w = m_write && !pw;
            if (m_read && m_write) chk("strobe_exclusive", 32'(m_read & m_write), 32'h0);
            if (rise_r || rise_w) begin
                n_rises++;
                chk("strobe_low_gap", 32'(lo_run >= 3), 32'h1);
                lo_run = 0;
                hi_run = 0;
                if (exp_cmd.size() == 0) begin
                    chk("unexpected_strobe", m_address, 32'hFFFF_FFFF);
                end else begin
                    c = exp_cmd.pop_front();
                    chk("cmd_kind_is_write", 32'(rise_w), 32'(c.wr));
                    chk("cmd_address", m_address, c.a);
                    if (c.wr) chk("cmd_writedata", m_writedata, c.d);
                end
            end
            if (!chk_spacing) have_prev = 1'b0;
            else if (rise_w) begin
                if (have_prev) chk("wr_strobe_spacing", 32'(cyc - prev_rise), 32'(c_WR_PERIOD));
                have_prev = 1'b1;
                prev_rise = cyc;
            end
            if (m_read || m_write) begin
                hi_run++;
            end else begin
                if (pr || pw) chk("strobe_width", 32'(hi_run), 32'd2);
                if (pr) last_rd_fall = cyc;
                lo_run++;
            end
            if (h_readdatavalid) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_response", h_readdata, 32'hFFFF_FFFF);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_data", h_readdata, r.d);
                    if (r.lat >= 0) chk("rsp_latency", 32'(cyc - last_rd_fall), 32'(r.lat));
                end
            end
            pr = m_read;
            pw = m_write;
        end
    end

    // Issue one host request, wait for acceptance, and push its expectations
    task automatic host_req(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd, input int lat);
        logic ok;
        cmd_t c;
        rsp_t r;
        ok = 1'b0;
        h_read = rd; h_write = wr; h_address = a; h_writedata = d;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            ok = !h_waitrequest;
            @(posedge clk);
            #1;
        end
        h_read = 1'b0;
        h_write = 1'b0;
        if (!ok) begin
            chk("host_accept_timeout", 32'h0, 32'h1);
        end else begin
            c.wr = wr; c.a = a; c.d = d;
            exp_cmd.push_back(c);
            if (!wr) begin
                r.d = exp_rd; r.lat = lat;
                exp_rsp.push_back(r);
            end
        end
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(posedge clk);
            #1;
            done = !busy;
        end
        if (!done) chk("idle_timeout", 32'(busy), 32'h0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_waitrequest"}, 32'(h_waitrequest), 32'h0);
        chk({tag, "_readdata"}, h_readdata, 32'h0);
        chk({tag, "_readdatavalid"}, 32'(h_readdatavalid), 32'h0);
        chk({tag, "_m_address"}, m_address, 32'h0);
        chk({tag, "_m_read"}, 32'(m_read), 32'h0);
        chk({tag, "_m_write"}, 32'(m_write), 32'h0);
        chk({tag, "_m_writedata"}, m_writedata, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_rd_timeout_err"}, 32'(rd_timeout_err), 32'h0);
        chk({tag, "_proto_err"}, 32'(proto_err), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        int rises_before;
        n_total = 0; n_pass = 0; n_rises = 0;
        rst = 1'b1; h_read = 1'b0; h_write = 1'b0; h_address = '0; h_writedata = '0;
        ctl_respond = 1'b1; chk_spacing = 1'b0;
        ctl_mem[32'h40] = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Single read with a normal response
        host_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, -1);
        wait_idle();
        chk("t1_rsp_drained", 32'(exp_rsp.size()), 32'h0);
        chk("t1_timeout_err", 32'(rd_timeout_err), 32'h0);

        // Fill the FIFO behind an in-flight write, then drain
        chk_spacing = 1'b1;
        host_req(1'b0, 1'b1, 32'h0000_1000, 32'hC0DE_0000, 32'h0, -1);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 1; k <= 10; k++) begin
            host_req(1'b0, 1'b1, 32'h0000_1000 + 32'(k * 4), 32'hC0DE_0000 + 32'(k), 32'h0, -1);
            chk($sformatf("t2_waitrequest_after_%0d", k), 32'(h_waitrequest), 32'(k >= 8));
        end
        wait_idle();
        chk_spacing = 1'b0;
        chk("t2_cmd_drained", 32'(exp_cmd.size()), 32'h0);

        // Read with no controller response, followed by a write
        ctl_respond = 1'b0;
        host_req(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'hDEAD_BEEF, 255);
        host_req(1'b0, 1'b1, 32'h0000_0084, 32'h0000_0077, 32'h0, -1);
        wait_idle();
        ctl_respond = 1'b1;
        chk("t3_timeout_err", 32'(rd_timeout_err), 32'h1);
        chk("t3_cmd_drained", 32'(exp_cmd.size()), 32'h0);

        // Interleaved writes and reads
        host_req(1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0, -1);
        host_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'hA5A5_A5A5, -1);
        host_req(1'b0, 1'b1, 32'h0000_0004, 32'h0000_0001, 32'h0, -1);
        host_req(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_0001, -1);
        wait_idle();
        chk("t4_rsp_drained", 32'(exp_rsp.size()), 32'h0);
        chk("t4_timeout_err_sticky", 32'(rd_timeout_err), 32'h1);
        chk("t4_proto_err", 32'(proto_err), 32'h0);

        // Simultaneous read and write
        host_req(1'b1, 1'b1, 32'h0000_0200, 32'h0000_005A, 32'h0, -1);
        chk("t5_proto_err", 32'(proto_err), 32'h1);
        wait_idle();
        chk("t5_cmd_drained", 32'(exp_cmd.size()), 32'h0);

        // Reset during a write wait with three entries still queued
        for (int k = 0; k < 4; k++) begin
            host_req(1'b0, 1'b1, 32'h0000_0300 + 32'(k * 4), 32'h0000_1110 + 32'(k), 32'h0, -1);
        end
        repeat (8) @(posedge clk);
        #1;
        chk("t6_busy_before_reset", 32'(busy), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("t6_reset");
        exp_cmd.delete();
        exp_rsp.delete();
        rst = 1'b0;
        rises_before = n_rises;
        repeat (150) @(posedge clk);
        #1;
        chk("t6_no_strobes_after_reset", 32'(n_rises - rises_before), 32'h0);
        chk("t6_busy_idle", 32'(busy), 32'h0);

        // Normal operation resumes after reset
        host_req(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_0001, -1);
        wait_idle();
        chk("t6_rsp_drained", 32'(exp_rsp.size()), 32'h0);
        chk("t6_cmd_drained", 32'(exp_cmd.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
